packet_read_adapter: RTL and testbench
======================================

Name: packet_read_adapter

Overview:
Upstream feeder for the BPF CPU core's packet loads. It takes a byte-addressed load request (byte, half or word size) and issues one or two reads to the 32-bit-wide packet RAM. It assembles the big-endian, zero-extended result and returns it with a one-cycle mem_ready pulse. It also range-checks every request against the current packet length and flags out-of-bounds loads.

Parameters:
PACKET_BYTE_ADDR_WIDTH, 12, width of the byte address.
PACKET_ADDR_WIDTH, PACKET_BYTE_ADDR_WIDTH-2, width of the RAM word address.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
rd_en  input  1  load request strobe from CPU
byte_addr  input  PACKET_BYTE_ADDR_WIDTH  byte address of load
transfer_sz  input  2  00 word, 01 half, 10 byte, 11 reserved
packet_len  input  PACKET_BYTE_ADDR_WIDTH+1  packet length in bytes, stable during request
packet_data  output  32  assembled load result
mem_ready  output  1  one-cycle completion pulse
oob  output  1  valid with mem_ready: request was out of bounds
busy  output  1  request in flight
ram_rd_en  output  1  packet RAM read enable
ram_addr  output  PACKET_ADDR_WIDTH  packet RAM word address
ram_rd_data  input  32  RAM data, valid the cycle after ram_rd_en

Behaviour:
- Byte order: byte 4k+0 is word k bits [31:24], and byte 4k+3 is bits [7:0].
- Size and offset: size n = 4, 2 or 1; offset o = byte_addr[1:0]. A request crosses a word boundary when o+n > 4.
- Bounds check: a request is oob when transfer_sz = 11 or byte_addr + n > packet_len. Compute the sum at PACKET_BYTE_ADDR_WIDTH+1 bits so it cannot overflow.
- FSM states: IDLE, WAIT1, WAIT2. busy = (state != IDLE).
- IDLE with rd_en=1 (cycle 0): latch byte_addr, transfer_sz and o.
  - oob request: no RAM read. Next cycle: mem_ready=1, oob=1, packet_data=0. Stay in IDLE.
  - Otherwise: ram_rd_en=1 and ram_addr=byte_addr[W-1:2], both combinational in cycle 0. Go to WAIT1.
- WAIT1 (cycle 1): ram_rd_data = word0.
  - Not crossing: register the result. mem_ready=1, oob=0 in cycle 2. Go to IDLE.
  - Crossing: store word0; drive ram_rd_en=1 and ram_addr=word0 address+1. Go to WAIT2.
- WAIT2 (cycle 2): ram_rd_data = word1. Register the result; mem_ready=1 in cycle 3. Go to IDLE.
- Latency: 1 cycle for oob, 2 for aligned or non-crossing, 3 for crossing.
- Result assembly: take the 8-byte stream {word0, word1} and select bytes o..o+n-1.
  - Word result: bytes packed MSB first.
  - Half result: {16'b0, two bytes}.
  - Byte result: {24'b0, byte}.
  - A byte load never crosses.
- mem_ready and oob are one-cycle pulses. oob=0 whenever mem_ready=0.
- packet_data holds its value until the next completion.
- rd_en while busy is ignored; no queueing.
- rd_en in the same cycle as a mem_ready pulse is accepted, because state is already IDLE.
- Outside cycle 0 and the WAIT1 crossing cycle, ram_rd_en=0 and ram_addr=0.
- A crossing request on the last RAM word is always oob, so ram_addr never wraps.
- Reset values: state=IDLE, mem_ready=0, oob=0, packet_data=0, ram_rd_en=0, ram_addr=0.
- Reset mid-transaction aborts the transaction: no mem_ready is produced, and any RAM data still returning is discarded.

Test Plan:
1. RAM word0=0xAABBCCDD, len=64. Word load at addr 0, rd_en at cycle 0 -> ram_rd_en cycle 0 at addr 0; mem_ready cycle 2; packet_data=0xAABBCCDD; oob=0.
2. word0=0x11223344, word1=0x55667788. Word load at addr 2 -> two RAM reads (addr 0, then 1); mem_ready cycle 3; data=0x33445566. Half load at addr 3 -> data=0x00004455, latency 3.
3. Byte load at addr 5, word1=0x55667788 -> data=0x00000066, single read, latency 2. Half load at addr 6 -> data=0x00007788, single read.
4. len=10. Word load at addr 7 -> oob=1, data=0, mem_ready cycle 1, no ram_rd_en. Half load at addr 8 -> in bounds, data correct. transfer_sz=11 -> oob=1.
5. Back-to-back requests: issue rd_en in the mem_ready cycle -> accepted with no bubble. rd_en asserted in WAIT1 -> ignored, exactly one mem_ready.
6. Assert rst during WAIT2 of a crossing load -> no mem_ready; all outputs zero next cycle. A following aligned load completes normally.

Source files
------------

// File: rtl/packet_read_adapter_if.sv
// rtl/packet_read_adapter_if.sv - CPU load request/response and packet RAM read signals for packet_read_adapter
interface packet_read_adapter_if #(
    parameter int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) ();
    logic                              rd_en;
    logic [PACKET_BYTE_ADDR_WIDTH-1:0] byte_addr;
    logic [1:0]                        transfer_sz;
    logic [PACKET_BYTE_ADDR_WIDTH:0]   packet_len;
    logic [31:0]                       packet_data;
    logic                              mem_ready;
    logic                              oob;
    logic                              busy;
    logic                              ram_rd_en;
    logic [PACKET_ADDR_WIDTH-1:0]      ram_addr;
    logic [31:0]                       ram_rd_data;

    modport slave (
        input  rd_en, byte_addr, transfer_sz, packet_len, ram_rd_data,
        output packet_data, mem_ready, oob, busy, ram_rd_en, ram_addr
    );

    modport master (
        output rd_en, byte_addr, transfer_sz, packet_len, ram_rd_data,
        input  packet_data, mem_ready, oob, busy, ram_rd_en, ram_addr
    );
endinterface

// File: rtl/packet_read_adapter.sv
// rtl/packet_read_adapter.sv - byte/half/word packet loads from 32-bit packet RAM with bounds check
module packet_read_adapter #(
    parameter int PACKET_BYTE_ADDR_WIDTH = 12,
    parameter int PACKET_ADDR_WIDTH      = PACKET_BYTE_ADDR_WIDTH - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    packet_read_adapter_if.slave  bus
);
    localparam int W = PACKET_BYTE_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, WAIT1, WAIT2} state_t;

    state_t         state, state_d;
    logic [W-1:0]   addr_q;
    logic [1:0]     sz_q;
    logic           crossing_q;
    logic [31:0]    word0_q;
    logic [31:0]    data_q;
    logic           mem_ready_q;
    logic           oob_q;

    logic [2:0]     req_n;
    logic [W:0]     end_sum;
    logic           req_oob;
    logic           req_crossing;
    logic [63:0]    stream;
    logic [63:0]    shifted;
    logic [31:0]    assembled;

    always_comb begin
        case (bus.transfer_sz)
            2'b00:   req_n = 3'd4;
            2'b01:   req_n = 3'd2;
            2'b10:   req_n = 3'd1;
            default: req_n = 3'd0;
        endcase
    end

    // A request ending past the top of the RAM would wrap the word address,
    // so it is rejected even if packet_len claims more bytes.
    assign end_sum      = {1'b0, bus.byte_addr} + {{(W-2){1'b0}}, req_n};
    assign req_oob      = (bus.transfer_sz == 2'b11) || (end_sum > bus.packet_len)
                          || (end_sum > {1'b1, {W{1'b0}}});
    assign req_crossing = ({1'b0, bus.byte_addr[1:0]} + req_n) > 3'd4;

    assign stream    = (state == WAIT2) ? {word0_q, bus.ram_rd_data} : {bus.ram_rd_data, 32'h0};
    assign shifted   = stream << {addr_q[1:0], 3'b000};

    always_comb begin
        case (sz_q)
            2'b00:   assembled = shifted[63:32];
            2'b01:   assembled = {16'h0, shifted[63:48]};
            default: assembled = {24'h0, shifted[63:56]};
        endcase
    end

    always_comb begin
        state_d       = state;
        bus.ram_rd_en = 1'b0;
        bus.ram_addr  = '0;
        case (state)
            IDLE: begin
                if (bus.rd_en && !req_oob) begin
                    bus.ram_rd_en = 1'b1;
                    bus.ram_addr  = bus.byte_addr[W-1:2];
                    state_d       = WAIT1;
                end
            end
            WAIT1: begin
                if (crossing_q) begin
                    bus.ram_rd_en = 1'b1;
                    bus.ram_addr  = addr_q[W-1:2] + PACKET_ADDR_WIDTH'(1);
                    state_d       = WAIT2;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            sz_q        <= '0;
            crossing_q  <= 1'b0;
            word0_q     <= '0;
            data_q      <= '0;
            mem_ready_q <= 1'b0;
            oob_q       <= 1'b0;
        end else begin
            state       <= state_d;
            mem_ready_q <= 1'b0;
            oob_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.rd_en) begin
                        addr_q     <= bus.byte_addr;
                        sz_q       <= bus.transfer_sz;
                        crossing_q <= req_crossing;
                        if (req_oob) begin
                            mem_ready_q <= 1'b1;
                            oob_q       <= 1'b1;
                            data_q      <= '0;
                        end
                    end
                end
                WAIT1: begin
                    if (crossing_q) begin
                        word0_q <= bus.ram_rd_data;
                    end else begin
                        data_q      <= assembled;
                        mem_ready_q <= 1'b1;
                    end
                end
                default: begin
                    data_q      <= assembled;
                    mem_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.packet_data = data_q;
    assign bus.mem_ready   = mem_ready_q;
    assign bus.oob         = oob_q;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_packet_read_adapter.sv
// tb/tb_packet_read_adapter.sv - directed scoreboard bench for packet_read_adapter
module tb_packet_read_adapter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   rd_cnt = 0;

    always #5 clk = ~clk;

    packet_read_adapter_if #(.PACKET_BYTE_ADDR_WIDTH(12)) bus ();

    packet_read_adapter #(.PACKET_BYTE_ADDR_WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] mem [0:1023];

    always @(posedge clk) begin
        if (bus.ram_rd_en) bus.ram_rd_data <= mem[bus.ram_addr];
        if (bus.ram_rd_en) rd_cnt <= rd_cnt + 1;
    end

    typedef struct {
        logic [31:0] data;
        logic        oob;
        int          lat;
        int          reads;
        int          rd_base;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [11:0] a, input logic [1:0] sz,
                         input logic [31:0] ed, input logic eo, input int el, input int er);
        exp_t e;
        e.data = ed; e.oob = eo; e.lat = el; e.reads = er; e.rd_base = rd_cnt;
        sb.push_back(e);
        bus.rd_en       = 1'b1;
        bus.byte_addr   = a;
        bus.transfer_sz = sz;
        #1;
        chk({tag, " c0 ram_rd_en"}, 32'(bus.ram_rd_en), 32'(!eo));
        chk({tag, " c0 ram_addr"}, 32'(bus.ram_addr), eo ? 32'h0 : 32'(a[11:2]));
    endtask

    task automatic finish_resp(input string tag);
        exp_t e;
        int lat;
        @(negedge clk);
        bus.rd_en = 1'b0;
        lat = 1;
        while (bus.mem_ready !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk({tag, " mem_ready"}, 32'(bus.mem_ready), 32'h1);
        chk({tag, " latency"}, 32'(lat), 32'(e.lat));
        chk({tag, " data"}, bus.packet_data, e.data);
        chk({tag, " oob"}, 32'(bus.oob), 32'(e.oob));
        chk({tag, " reads"}, 32'(rd_cnt - e.rd_base), 32'(e.reads));
    endtask

    initial begin
        exp_t d;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.rd_en       = 1'b0;
        bus.byte_addr   = '0;
        bus.transfer_sz = 2'b00;
        bus.packet_len  = 13'd64;
        mem[0] = 32'hAABBCCDD;
        mem[1] = 32'h55667788;
        mem[2] = 32'h99AABBCC;

        repeat (3) @(negedge clk);
        chk("rst mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("rst oob", 32'(bus.oob), 32'h0);
        chk("rst data", bus.packet_data, 32'h0);
        chk("rst busy", 32'(bus.busy), 32'h0);
        chk("rst ram_rd_en", 32'(bus.ram_rd_en), 32'h0);
        chk("rst ram_addr", 32'(bus.ram_addr), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        issue("t1 word0", 12'd0, 2'b00, 32'hAABBCCDD, 1'b0, 2, 1);
        finish_resp("t1 word0");
        repeat (2) @(negedge clk);
        chk("t1 hold data", bus.packet_data, 32'hAABBCCDD);
        chk("t1 pulse", 32'(bus.mem_ready), 32'h0);

        mem[0] = 32'h11223344;
        issue("t2 word2", 12'd2, 2'b00, 32'h33445566, 1'b0, 3, 2);
        finish_resp("t2 word2");
        @(negedge clk);
        issue("t2 half3", 12'd3, 2'b01, 32'h00004455, 1'b0, 3, 2);
        finish_resp("t2 half3");
        @(negedge clk);

        issue("t3 byte5", 12'd5, 2'b10, 32'h00000066, 1'b0, 2, 1);
        finish_resp("t3 byte5");
        @(negedge clk);
        issue("t3 half6", 12'd6, 2'b01, 32'h00007788, 1'b0, 2, 1);
        finish_resp("t3 half6");
        @(negedge clk);

        bus.packet_len = 13'd10;
        issue("t4 word7", 12'd7, 2'b00, 32'h0, 1'b1, 1, 0);
        finish_resp("t4 word7");
        @(negedge clk);
        issue("t4 half8", 12'd8, 2'b01, 32'h000099AA, 1'b0, 2, 1);
        finish_resp("t4 half8");
        @(negedge clk);
        issue("t4 byte9", 12'd9, 2'b10, 32'h000000AA, 1'b0, 2, 1);
        finish_resp("t4 byte9");
        @(negedge clk);
        issue("t4 byte10", 12'd10, 2'b10, 32'h0, 1'b1, 1, 0);
        finish_resp("t4 byte10");
        @(negedge clk);
        issue("t4 rsvd", 12'd0, 2'b11, 32'h0, 1'b1, 1, 0);
        finish_resp("t4 rsvd");
        @(negedge clk);

        bus.packet_len = 13'd64;
        issue("t5 b2b a", 12'd4, 2'b00, 32'h55667788, 1'b0, 2, 1);
        finish_resp("t5 b2b a");
        issue("t5 b2b b", 12'd1, 2'b01, 32'h00002233, 1'b0, 2, 1);
        finish_resp("t5 b2b b");
        @(negedge clk);

        issue("t5 ign", 12'd0, 2'b10, 32'h00000011, 1'b0, 2, 1);
        @(negedge clk);
        bus.byte_addr   = 12'd4;
        bus.transfer_sz = 2'b00;
        #1;
        chk("t5 ign c1 ram_rd_en", 32'(bus.ram_rd_en), 32'h0);
        @(negedge clk);
        bus.rd_en = 1'b0;
        d = sb.pop_front();
        chk("t5 ign mem_ready", 32'(bus.mem_ready), 32'h1);
        chk("t5 ign data", bus.packet_data, d.data);
        chk("t5 ign reads", 32'(rd_cnt - d.rd_base), 32'(d.reads));
        @(negedge clk);
        chk("t5 ign single", 32'(bus.mem_ready), 32'h0);
        chk("t5 ign busy", 32'(bus.busy), 32'h0);
        @(negedge clk);

        issue("t6 cross", 12'd3, 2'b00, 32'h44556677, 1'b0, 3, 2);
        @(negedge clk);
        bus.rd_en = 1'b0;
        #1;
        chk("t6 c1 ram_rd_en", 32'(bus.ram_rd_en), 32'h1);
        chk("t6 c1 ram_addr", 32'(bus.ram_addr), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("t6 rst mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("t6 rst data", bus.packet_data, 32'h0);
        chk("t6 rst oob", 32'(bus.oob), 32'h0);
        chk("t6 rst busy", 32'(bus.busy), 32'h0);
        chk("t6 rst ram_rd_en", 32'(bus.ram_rd_en), 32'h0);
        chk("t6 rst ram_addr", 32'(bus.ram_addr), 32'h0);
        @(negedge clk);
        chk("t6 no late ready", 32'(bus.mem_ready), 32'h0);
        issue("t6 after", 12'd4, 2'b00, 32'h55667788, 1'b0, 2, 1);
        finish_resp("t6 after");
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
